// File: rtl/div32b_iter.sv
// div32b_iter: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div32b_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_resp_valid,
   input  logic             i_resp_ready,
   output logic [WIDTH-1:0] o_result
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem, quo, dsr, result;
   logic             op_rem, neg_q, neg_r;
   logic             sgn, a_neg, b_neg, div0, ovf, accept;
   logic [WIDTH-1:0] abs_a, abs_b, spec_res, q_fix, r_fix;
   logic [WIDTH:0]   trial;
   assign o_req_ready  = state == S_IDLE;
   assign o_resp_valid = state == S_DONE;
   assign o_result     = result;
   // request decode: operand magnitudes and the two short-circuit cases
   always_comb begin
      sgn      = ~i_op[0];
      a_neg    = sgn & i_dividend[WIDTH-1];
      b_neg    = sgn & i_divisor[WIDTH-1];
      abs_a    = a_neg ? -i_dividend : i_dividend;
      abs_b    = b_neg ? -i_divisor : i_divisor;
      div0     = i_divisor == '0;
      ovf      = sgn & (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (i_divisor == '1);
      spec_res = div0 ? (i_op[1] ? i_dividend : '1)
                      : (i_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});
      accept   = i_req_valid & o_req_ready;
   end
   // one restoring step: the shifted remainder can reach WIDTH+1 bits
   always_comb begin
      trial = {rem, quo[WIDTH-1]} - {1'b0, dsr};
      q_fix = neg_q ? -quo : quo;
      r_fix = neg_r ? -rem : rem;
   end
   // control FSM and datapath registers; reset beats flush beats handshakes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dsr    <= '0;
         result <= '0;
         op_rem <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (i_flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               op_rem <= i_op[1];
               neg_q  <= a_neg ^ b_neg;
               neg_r  <= a_neg;
               dsr    <= abs_b;
               rem    <= '0;
               quo    <= abs_a;
               cnt    <= '0;
               if (div0 | ovf) begin
                  result <= spec_res;
                  state  <= S_DONE;
               end else begin
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               rem   <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
               quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
               cnt   <= cnt + 1'b1;
               state <= (cnt == CNT_W'(WIDTH-1)) ? S_FIX : S_CALC;
            end
            S_FIX: begin
               result <= op_rem ? r_fix : q_fix;
               state  <= S_DONE;
            end
            default: if (i_resp_ready) state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div32b_iter.sv
// tb_div32b_iter: directed vector table plus handshake, flush and reset sequences
module tb_div32b_iter;
   logic        clk = 0;
   logic        rst_n = 0;
   logic        flush = 0;
   logic        req_valid = 0;
   logic        req_ready;
   logic [1:0]  op = 0;
   logic [31:0] dividend = 0;
   logic [31:0] divisor = 0;
   logic        resp_valid;
   logic        resp_ready = 0;
   logic [31:0] result;
   int total = 0;
   int bad = 0;
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t v[20];
   div32b_iter dut (
      .clk(clk), .rst_n(rst_n), .i_flush(flush),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_op(op), .i_dividend(dividend), .i_divisor(divisor),
      .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
      .o_result(result)
   );
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // drive a request at a negedge; it is accepted on the following posedge
   task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; dividend = a; divisor = b; req_valid = 1;
      @(posedge clk);
      #1 req_valid = 0;
   endtask
   // count cycles after the accept edge until resp_valid, bounded
   task automatic wait_resp(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!resp_valid && cyc < 100);
   endtask
   task automatic take_resp();
      @(negedge clk);
      resp_ready = 1;
      @(posedge clk);
      #1 resp_ready = 0;
   endtask
   task automatic run(input string nm, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
      int cyc;
      start(o, a, b);
      wait_resp(cyc);
      check({nm, " latency"}, cyc, lat);
      check({nm, " result"}, result, exp);
      take_resp();
      check({nm, " valid drop"}, {31'd0, resp_valid}, 0);
   endtask
   initial begin
      int cyc;
      logic seen;
      v[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
      v[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
      v[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
      v[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
      v[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
      v[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      v[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1};
      v[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      v[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      v[9]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
      v[10] = '{2'b01, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  34};
      v[11] = '{2'b11, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  34};
      v[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
      v[13] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
      v[14] = '{2'b01, 32'd3,          32'd5,          32'd0,          34};
      v[15] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
      v[16] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34};
      v[17] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34};
      v[18] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  34};
      v[19] = '{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  34};
      repeat (3) @(posedge clk);
      #1;
      check("reset resp_valid", {31'd0, resp_valid}, 0);
      check("reset result", result, 0);
      check("reset req_ready", {31'd0, req_ready}, 1);
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < 20; i++) run($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].exp, v[i].lat);
      // backpressure: result held, no accept while DONE, accept only after handshake
      start(2'b01, 32'd100, 32'd7);
      wait_resp(cyc);
      check("bp latency", cyc, 34);
      op = 2'b01; dividend = 32'd200; divisor = 32'd7; req_valid = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("bp hold valid %0d", i), {31'd0, resp_valid}, 1);
         check($sformatf("bp hold result %0d", i), result, 14);
         check($sformatf("bp hold ready %0d", i), {31'd0, req_ready}, 0);
      end
      resp_ready = 1;
      @(posedge clk);
      #1 resp_ready = 0;
      check("bp after hs valid", {31'd0, resp_valid}, 0);
      check("bp after hs ready", {31'd0, req_ready}, 1);
      @(posedge clk);
      #1 req_valid = 0;
      check("bp second accepted", {31'd0, req_ready}, 0);
      wait_resp(cyc);
      check("bp second latency", cyc, 34);
      check("bp second result", result, 28);
      take_resp();
      // flush in the middle of CALC
      start(2'b01, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      flush = 1;
      @(posedge clk);
      #1 flush = 0;
      check("flush idle", {31'd0, req_ready}, 1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         seen |= resp_valid;
      end
      check("flush no resp", {31'd0, seen}, 0);
      run("post flush", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
      // flush wins over a same-cycle request
      @(negedge clk);
      op = 2'b00; dividend = 32'd5; divisor = 32'd0; req_valid = 1; flush = 1;
      @(posedge clk);
      #1 req_valid = 0; flush = 0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         seen |= resp_valid | ~req_ready;
      end
      check("flush beats req", {31'd0, seen}, 0);
      // reset in the middle of CALC
      start(2'b01, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      rst_n = 0;
      @(posedge clk);
      #1;
      check("midrst resp_valid", {31'd0, resp_valid}, 0);
      check("midrst result", result, 0);
      check("midrst idle", {31'd0, req_ready}, 1);
      @(negedge clk) rst_n = 1;
      run("post reset", 2'b11, 32'd100, 32'd7, 32'd2, 34);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div32b_iter.md
Name: div32b_iter

Overview:
Iterative radix-2 restoring divider that implements RV32M DIV/DIVU/REM/REMU. It is the inverse-operation companion to the one-cycle Booth/CSA multiplier in the core's mult/div unit. Operands arrive via a valid/ready request handshake. The result leaves via a valid/ready response handshake. One division is in flight at a time; the result is available after a fixed, data-independent latency.

Parameters:
WIDTH, 32, operand/result width in bits (only 32 is verified)
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
i_flush  input  1  pipeline flush; aborts any in-flight division
i_req_valid  input  1  request valid
o_req_ready  output  1  divider can accept a request (high only in IDLE)
i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
i_dividend  input  WIDTH  rs1 value
i_divisor  input  WIDTH  rs2 value
o_resp_valid  output  1  result valid
i_resp_ready  input  1  consumer accepts the result
o_result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; o_resp_valid=0; o_result=0; counter=0; all working registers cleared. Reset has priority over flush and over any handshake. Reset asserted mid-operation discards the operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - o_req_ready=1.
  - Accept when i_req_valid & o_req_ready: latch the op and the operand signs. Load |dividend| and |divisor| for signed ops, or the raw operands for unsigned ops.
  - Divisor==0: go to DONE with quotient=all-ones and remainder=dividend (raw, unmodified).
  - Signed op with dividend=0x8000_0000 and divisor=0xFFFF_FFFF: go to DONE with quotient=0x8000_0000 and remainder=0.
  - Otherwise go to CALC with counter=0, remainder register=0, quotient register=|dividend|.
- CALC, one bit per cycle for WIDTH cycles:
  - Shift {rem,quo} left 1 and form trial=rem_shifted − divisor, a (WIDTH+1)-bit subtract.
  - trial non-negative: rem=trial, quo LSB=1. Otherwise keep rem_shifted, quo LSB=0.
  - After counter==WIDTH−1, go to FIX.
- FIX, one cycle:
  - Negate the quotient if the op is signed and the dividend and divisor signs differ.
  - Negate the remainder if the op is signed and the dividend is negative.
  - Select the quotient or remainder per op[1]; register it into o_result; go to DONE.
- DONE:
  - o_resp_valid=1 and o_result stable until i_resp_ready=1.
  - On that edge o_resp_valid drops to 0 and the state returns to IDLE.
  - o_req_ready stays 0 in DONE; no back-to-back accept in the same cycle.
- Latency:
  - Normal case: accept edge at cycle 0, o_resp_valid=1 in cycle WIDTH+2 (34 for WIDTH=32).
  - Special cases: o_resp_valid=1 in cycle 1.
- i_flush=1 in any state: next state IDLE, o_resp_valid=0, no result delivered. Flush in the same cycle as a request wins, so the request is not accepted.
- o_result holds its last value in IDLE; the consumer must qualify it with o_resp_valid.
- Negation is two's complement modulo 2^WIDTH.

Test Plan:
- DIVU 100/7: accepted cycle 0 -> o_resp_valid cycle 34, o_result=14; REMU same operands -> 2.
- DIV −7/2 (0xFFFF_FFF9, 2) -> quotient 0xFFFF_FFFD (−3); REM -> 0xFFFF_FFFF (−1). REM 7/−2 -> 1.
- Divide by zero, DIV 5/0 -> o_result=0xFFFF_FFFF at cycle 1; REMU 5/0 -> 5.
- Overflow, DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM -> 0; both at cycle 1.
- Backpressure: hold i_resp_ready=0 for 10 cycles after o_resp_valid -> o_result stable and o_req_ready=0 throughout; a new request is accepted only in the cycle after the response handshake.
- Abort:
  - i_flush at cycle 10 of CALC -> IDLE next cycle, no o_resp_valid; the next request DIVU 0xFFFF_FFFF/1 completes with 0xFFFF_FFFF.
  - rst_n=0 mid-CALC -> all outputs 0 and IDLE on the next edge.
